// File: rtl/sb_req_arbiter_pkg.sv
// Shared definitions for the scoreboard front end: memory opcode encodings,
// the memory-op predicate used by both arbiter and scoreboard, and small helpers.
package sb_req_arbiter_pkg;

    localparam int unsigned MEM_OPCODE_READ       = 1;
    localparam int unsigned MEM_OPCODE_WRITE_ADDR = 2;

    typedef enum logic {
        GRANT_RR,
        GRANT_STARVE
    } grant_src_e;

    // Opcodes are zero-extended by the caller so one function serves any OPCODE_W.
    function automatic logic is_mem_opcode(input logic [31:0] opcode);
        return (opcode == 32'(MEM_OPCODE_READ)) || (opcode == 32'(MEM_OPCODE_WRITE_ADDR));
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sb_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// wrapping modulo NUM_REQ, returned as one-hot grant plus binary index.
module rr_pick
    import sb_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    always_comb begin
        int unsigned idx;
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        idx         = 0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        // Walk from the farthest candidate back to ptr so the closest eligible one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (eligible[idx]) begin
                grant_idx   = IDX_W'(idx);
                grant_valid = 1'b1;
            end
        end
        grant = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/sb_req_arbiter.sv
// Scoreboard request arbiter: one grant per cycle, round-robin with a
// starvation override, memory ops gated by sb_mem_ready_i and a one-cycle hold.
module sb_req_arbiter
    import sb_req_arbiter_pkg::*;
#(
    parameter int                          NUM_REQ      = 4,
    parameter int                          SRC_ID_W     = 4,
    parameter int                          OPCODE_W     = 2,
    parameter logic [SRC_ID_W*NUM_REQ-1:0] REQ_SRC_IDS  = '0,
    parameter int                          AGE_W        = 4,
    parameter int                          STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*OPCODE_W-1:0] req_opcode_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic                        sb_mem_ready_i,
    output logic                        sb_req_valid_o,
    output logic [SRC_ID_W-1:0]         sb_req_src_id_o,
    output logic [OPCODE_W-1:0]         sb_req_opcode_o
);

    localparam int               IDX_W      = idx_width(NUM_REQ);
    localparam logic [AGE_W-1:0] AGE_MAX    = '1;
    localparam logic [AGE_W-1:0] STARVE_AGE = AGE_W'(STARVE_LIMIT);

    logic [IDX_W-1:0]   rr_ptr;
    logic [AGE_W-1:0]   age [NUM_REQ];
    logic               mem_hold;

    logic [NUM_REQ-1:0] is_mem;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] starved;
    logic [NUM_REQ-1:0] rr_grant;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_any;
    logic [IDX_W-1:0]   starve_idx;
    logic               starve_any;
    grant_src_e         grant_src;
    logic [NUM_REQ-1:0] grant_vec;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   next_ptr;

    // Eligibility comes first, so a starved but mem-blocked requester never stalls others.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            is_mem[i]   = is_mem_opcode(32'(req_opcode_i[i*OPCODE_W +: OPCODE_W]));
            eligible[i] = req_valid_i[i] && (!is_mem[i] || (sb_mem_ready_i && !mem_hold));
            starved[i]  = (NUM_REQ > 1) && eligible[i] && (age[i] >= STARVE_AGE);
        end
    end

    always_comb begin
        starve_idx = '0;
        starve_any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (starved[i]) begin
                starve_idx = IDX_W'(i);
                starve_any = 1'b1;
            end
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .eligible    (eligible),
        .ptr         (rr_ptr),
        .grant       (rr_grant),
        .grant_idx   (rr_idx),
        .grant_valid (rr_any)
    );

    always_comb begin
        grant_src = starve_any ? GRANT_STARVE : GRANT_RR;
        grant_vec = rr_grant;
        grant_idx = rr_idx;
        if (grant_src == GRANT_STARVE) begin
            grant_vec = NUM_REQ'(1) << starve_idx;
            grant_idx = starve_idx;
        end
        next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end

    // Gated by rst_n so no transfer can be signalled while the arbiter is held in reset.
    assign req_ready_o = rst_n ? grant_vec : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr          <= '0;
            mem_hold        <= 1'b0;
            sb_req_valid_o  <= 1'b0;
            sb_req_src_id_o <= '0;
            sb_req_opcode_o <= '0;
            // NOTE: the age array is a handful of flops and must start at zero,
            // so it is reset like any other register rather than left to a RAM.
            for (int i = 0; i < NUM_REQ; i++) age[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values of its neighbours, regardless of statement order.
            mem_hold <= rr_any && is_mem[grant_idx];
            if (rr_any) begin
                rr_ptr          <= next_ptr;
                sb_req_valid_o  <= 1'b1;
                sb_req_src_id_o <= REQ_SRC_IDS[grant_idx*SRC_ID_W +: SRC_ID_W];
                sb_req_opcode_o <= req_opcode_i[grant_idx*OPCODE_W +: OPCODE_W];
            end else begin
                sb_req_valid_o  <= 1'b0;
                sb_req_src_id_o <= '0;
                sb_req_opcode_o <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid_i[i] || grant_vec[i]) age[i] <= '0;
                else if (age[i] != AGE_MAX)          age[i] <= age[i] + AGE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sb_req_arbiter.sv
// Directed scoreboard bench: the driver checks req_ready_o and queues expected
// beats; an independent monitor pops and compares each sb_req_* beat.
module tb_sb_req_arbiter;
    import sb_req_arbiter_pkg::*;

    localparam int          NUM_REQ = 4;
    localparam logic [15:0] SRC_IDS = {4'd13, 4'd12, 4'd11, 4'd10};
    localparam logic [1:0]  ACC = 2'd0;
    localparam logic [1:0]  RD  = 2'(MEM_OPCODE_READ);
    localparam logic [1:0]  WA  = 2'(MEM_OPCODE_WRITE_ADDR);

    typedef struct {
        logic [3:0] v;
        logic [7:0] op;
        logic       mr;
        int         g;
    } vec_t;

    typedef struct {
        logic [3:0] src;
        logic [1:0] op;
        int         cyc;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_valid = '0;
    logic [7:0] req_opcode = '0;
    logic [3:0] req_ready;
    logic       mem_ready = 1'b0;
    logic       sb_valid;
    logic [3:0] sb_src;
    logic [1:0] sb_op;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    beat_t exp_q[$];
    vec_t  vecs[$];

    sb_req_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .SRC_ID_W     (4),
        .OPCODE_W     (2),
        .REQ_SRC_IDS  (SRC_IDS),
        .AGE_W        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid),
        .req_opcode_i    (req_opcode),
        .req_ready_o     (req_ready),
        .sb_mem_ready_i  (mem_ready),
        .sb_req_valid_o  (sb_valid),
        .sb_req_src_id_o (sb_src),
        .sb_req_opcode_o (sb_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ops(input logic [1:0] o3, input logic [1:0] o2,
                                       input logic [1:0] o1, input logic [1:0] o0);
        return {o3, o2, o1, o0};
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [7:0] op,
                                input logic mr, input int g);
        vec_t r;
        r.v = v; r.op = op; r.mr = mr; r.g = g;
        return r;
    endfunction

    task automatic apply(input vec_t vv);
        logic [3:0] exp_vec;
        beat_t      b;
        @(negedge clk);
        req_valid  = vv.v;
        req_opcode = vv.op;
        mem_ready  = vv.mr;
        #1;
        exp_vec = (vv.g < 0) ? 4'd0 : (4'd1 << vv.g);
        check("req_ready", 32'(req_ready), 32'(exp_vec));
        if (vv.g >= 0) begin
            b.src = SRC_IDS[vv.g*4 +: 4];
            b.op  = vv.op[vv.g*2 +: 2];
            b.cyc = cyc + 1;
            exp_q.push_back(b);
        end
    endtask

    // Monitor: every beat must match the head of the queue, in the expected cycle.
    initial begin
        beat_t b;
        forever begin
            @(posedge clk);
            #1;
            if (sb_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(sb_src), 32'hFFFF_FFFF);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_src", 32'(sb_src), 32'(b.src));
                    check("beat_op", 32'(sb_op), 32'(b.op));
                    check("beat_cycle", 32'(cyc), 32'(b.cyc));
                end
            end else begin
                check("idle_outputs_zero", {26'd0, sb_src, sb_op}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Round-robin over four accelerator requesters.
        for (int k = 0; k < 8; k++) vecs.push_back(mk(4'b1111, 8'h00, 1'b1, k % 4));
        vecs.push_back(mk(4'b0000, 8'h00, 1'b1, -1));
        // Memory gating: hold cycle after a memory grant, accelerator unaffected.
        vecs.push_back(mk(4'b0011, ops(ACC, ACC, RD, RD), 1'b1, 0));
        vecs.push_back(mk(4'b0010, ops(ACC, ACC, RD, ACC), 1'b1, -1));
        vecs.push_back(mk(4'b0010, ops(ACC, ACC, RD, ACC), 1'b1, 1));
        vecs.push_back(mk(4'b0100, ops(ACC, ACC, ACC, ACC), 1'b1, 2));
        vecs.push_back(mk(4'b1001, ops(ACC, ACC, ACC, RD), 1'b0, 3));
        vecs.push_back(mk(4'b1001, ops(ACC, ACC, ACC, RD), 1'b0, 3));
        vecs.push_back(mk(4'b0000, 8'h00, 1'b1, -1));
        // Starvation: requester 2 ages while mem-blocked, then wins over rr_ptr=0.
        for (int k = 0; k < 9; k++)
            vecs.push_back(mk(4'b1111, ops(ACC, WA, ACC, ACC), 1'b0, (k % 3 == 2) ? 3 : k % 3));
        vecs.push_back(mk(4'b1111, ops(ACC, WA, ACC, ACC), 1'b1, 2));
        vecs.push_back(mk(4'b1111, ops(ACC, WA, ACC, ACC), 1'b1, 3));
        vecs.push_back(mk(4'b1111, ops(ACC, WA, ACC, ACC), 1'b1, 0));
        vecs.push_back(mk(4'b0000, 8'h00, 1'b1, -1));
        // Withdrawal: blocked requester 1 drops valid; rr_ptr still points at 1.
        vecs.push_back(mk(4'b0010, ops(ACC, ACC, RD, ACC), 1'b0, -1));
        vecs.push_back(mk(4'b0010, ops(ACC, ACC, RD, ACC), 1'b0, -1));
        vecs.push_back(mk(4'b0000, 8'h00, 1'b0, -1));
        vecs.push_back(mk(4'b1111, 8'h00, 1'b1, 1));

        // Reset state with all requesters valid: ready must stay low.
        req_valid  = 4'b1111;
        mem_ready  = 1'b1;
        #2;
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_valid", 32'(sb_valid), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) apply(vecs[k]);

        // Asynchronous reset in the middle of the beat for requester 1.
        @(posedge clk);
        #3;
        check("prereset_beat_valid", 32'(sb_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(sb_valid), 32'd0);
        check("async_reset_src", 32'(sb_src), 32'd0);
        check("async_reset_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        apply(mk(4'b1111, 8'h00, 1'b1, 0));
        apply(mk(4'b1111, 8'h00, 1'b1, 1));
        apply(mk(4'b0000, 8'h00, 1'b1, -1));
        apply(mk(4'b0000, 8'h00, 1'b1, -1));

        @(posedge clk);
        #2;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
